dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Memory-stage sequencer directly upstream of the byte-addressable data memory.
- Accepts one load/store request at a time from the multicycle datapath and drives the memory's level-sensitive address, data and strobe inputs in safe setup/strobe phases.
- Captures read data, zero- or sign-extends byte loads, and implements byte stores as read-modify-write, because the memory always writes two bytes.
- Returns a response to the writeback stage.

Parameters:
- ADDR_W, 16, request and memory address width
- DATA_W, 16, data width (byte lane fixed at 8)
- MEM_BYTES, 32, implemented memory size in bytes; used for the range check

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle, can accept
- req_we  in  1  1=store, 0=load
- req_byte  in  1  1=byte access, 0=word access
- req_sext  in  1  byte load: 1=sign-extend, 0=zero-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data (byte store uses [7:0])
- mem_address  out  ADDR_W  to memory address
- mem_MemRd  out  1  to memory read strobe
- mem_MemWr  out  1  to memory write strobe
- mem_LB  out  1  to memory byte-load select
- mem_data_in  out  DATA_W  to memory write data
- mem_data_out  in  DATA_W  from memory read data
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes response
- resp_rdata  out  DATA_W  load result; 0 for stores and errors
- resp_err  out  1  access rejected, memory untouched

Behaviour:
- Reset is asynchronous and active-low; one clock.
- Reset values: state IDLE, req_ready=1, every other output 0.
- All memory-side outputs are registered.
- mem_MemRd and mem_MemWr are never high together.
- Address, data and LB are stable one full cycle before a strobe rises, and through the strobe cycle.
- Handshake: accept on the rising edge with req_valid && req_ready. req_ready = (state==IDLE). Request fields are latched at acceptance.
- Range check at acceptance: error if req_addr+1 >= MEM_BYTES, using ADDR_W+1-bit arithmetic so there is no wrap. Byte accesses are included, since the memory touches addr+1. On error: go to RESP, resp_err=1, resp_rdata=0, no strobe issued.
- States: IDLE, RD_SETUP, RD_STB, RD_CAP, WR_SETUP, WR_STB, RESP.
- Load: IDLE -> RD_SETUP -> RD_STB -> RD_CAP -> RESP.
  - RD_SETUP drives mem_address and mem_LB=req_byte.
  - RD_STB asserts mem_MemRd.
  - RD_CAP deasserts it and latches mem_data_out.
  - Byte result: {8{sext & d[7]}, d[7:0]}. Word result: d.
- Word store: IDLE -> WR_SETUP -> WR_STB -> RESP.
  - WR_SETUP drives mem_address and mem_data_in.
  - WR_STB asserts mem_MemWr.
- Byte store (read-modify-write): IDLE -> RD_SETUP (mem_LB=0) -> RD_STB -> RD_CAP -> WR_SETUP -> WR_STB -> RESP.
  - Write data = {captured[15:8], req_wdata[7:0]}.
- Latency, counted in edges from acceptance to resp_valid=1: load 4, word store 3, byte store 6, error 1.
- RESP: resp_valid, resp_rdata and resp_err are held stable until resp_ready. On the edge with resp_ready: clear resp_valid and return to IDLE. A new request can be accepted on the following edge, with no same-cycle bypass.
- req_valid while busy is ignored (req_ready=0). Requests are not dropped silently; the requester holds req_valid.
- rst_n low mid-operation clears the strobes immediately. A write already strobed may have landed; an interrupted RMW leaves memory either unchanged or fully written, never half-merged.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: word accesses (req_byte=0) with req_addr[0]=1 are rejected at acceptance, same as a range error (resp_err=1, 1-edge latency, no strobe).
- Undefined: odd word addresses are legal and access bytes addr and addr+1, little-endian.

Test Plan:
- Memory preloaded with mem[0]=07, mem[1]=00, mem[2]=81, mem[3]=11, mem[4]=22, mem[5]=22.
- Word load addr 0 -> resp_rdata=0x0007, resp_err=0, resp_valid 4 edges after acceptance, exactly one mem_MemRd cycle.
- Byte load addr 2: sext=1 -> 0xFF81; sext=0 -> 0x0081. mem_LB=1 throughout the read.
- Byte store addr 4 wdata 0x12AB, then word load addr 4 -> 0x22AB. mem[5] unchanged; the store responds at 6 edges with one MemRd pulse then one MemWr pulse.
- Word load addr 31 (MEM_BYTES=32) -> resp_err=1, resp_rdata=0, no strobe, response after 1 edge. Repeat with a byte store at addr 31 -> same.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0. Raise resp_ready -> IDLE next edge.
- Assert rst_n=0 during RD_STB of a byte store -> strobes drop immediately, all outputs reset, no MemWr issued. A fresh word load addr 4 then returns 0x2222.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Memory-stage sequencer: drives the data memory's level-sensitive strobes in setup/strobe phases,
// extends byte loads and turns byte stores into read-modify-write. Optional: DMEM_ALIGN_CHECK_EN.
module dmem_access_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_BYTES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic              req_sext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_MemRd,
  output logic              mem_MemWr,
  output logic              mem_LB,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_STB, RD_CAP, WR_SETUP, WR_STB, RESP
  } state_t;

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_t            state;
  logic              we_q, byte_q, sext_q;
  logic [7:0]        wbyte_q;
  logic [DATA_W-1:0] cap_q;
  logic [ADDR_W:0]   addr_end;
  logic              addr_err;

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] d,
                                                    input logic byt, input logic sext);
    logic signed [7:0]        lane;
    logic signed [DATA_W-1:0] wide;
    lane = d[7:0];
    wide = lane;
    if (!byt)     return d;
    else if (sext) return wide;
    else          return {{(DATA_W-8){1'b0}}, d[7:0]};
  endfunction

  function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] old_word,
                                                  input logic [7:0] new_byte);
    return {old_word[DATA_W-1:8], new_byte};
  endfunction

  assign req_ready = (state == IDLE);

  // The memory always touches addr+1, so byte accesses share the word range limit.
  always_comb begin
    addr_end = {1'b0, req_addr} + {{ADDR_W{1'b0}}, 1'b1};
    addr_err = (addr_end >= MEM_LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
    if (!req_byte && req_addr[0]) addr_err = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_address <= '0;
      mem_MemRd   <= 1'b0;
      mem_MemWr   <= 1'b0;
      mem_LB      <= 1'b0;
      mem_data_in <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          if (addr_err) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else if (!req_we || req_byte) begin
            state       <= RD_SETUP;
            mem_address <= req_addr;
            mem_LB      <= req_byte & ~req_we;
          end else begin
            state       <= WR_SETUP;
            mem_address <= req_addr;
            mem_data_in <= req_wdata;
            mem_LB      <= 1'b0;
          end
        end
        RD_SETUP: begin
          mem_MemRd <= 1'b1;
          state     <= RD_STB;
        end
        RD_STB: begin
          mem_MemRd <= 1'b0;
          state     <= RD_CAP;
        end
        RD_CAP: begin
          mem_LB <= 1'b0;
          if (we_q) begin
            mem_data_in <= rmw_merge(cap_q, wbyte_q);
            state       <= WR_SETUP;
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_extend(cap_q, byte_q, sext_q);
            state      <= RESP;
          end
        end
        WR_SETUP: begin
          mem_MemWr <= 1'b1;
          state     <= WR_STB;
        end
        WR_STB: begin
          mem_MemWr  <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is sampled on the edge that ends the strobe, while the memory still drives it.
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      we_q    <= req_we;
      byte_q  <= req_byte;
      sext_q  <= req_sext;
      wbyte_q <= req_wdata[7:0];
    end
    if (state == RD_STB) cap_q <= mem_data_out;
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: byte-array memory device plus a transaction-level
// reference model (separate byte array) driving directed and randomized load/store traffic.
module tb_dmem_access_ctrl;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MB = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we, req_byte, req_sext;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [AW-1:0] mem_address;
  logic          mem_MemRd, mem_MemWr, mem_LB;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          resp_valid, resp_ready, resp_err;
  logic [DW-1:0] resp_rdata;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem     [0:MB-1];
  logic [7:0] ref_mem [0:MB-1];
  logic       do_preload = 1'b0;
  logic [4:0] ma0, ma1;

  dmem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_BYTES(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_byte(req_byte),
    .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_address(mem_address), .mem_MemRd(mem_MemRd), .mem_MemWr(mem_MemWr),
    .mem_LB(mem_LB), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      0: return 8'h07;
      1: return 8'h00;
      2: return 8'h81;
      3: return 8'h11;
      4: return 8'h22;
      5: return 8'h22;
      default: return 8'(i * 37 + 3);
    endcase
  endfunction

  // Level-sensitive memory device: data only valid while the read strobe is high.
  assign ma0 = mem_address[4:0];
  assign ma1 = ma0 + 5'd1;
  assign mem_data_out = mem_MemRd ? {mem[ma1], mem[ma0]} : 16'hDEAD;

  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < MB; i++) mem[i] <= init_byte(i);
    end else if (mem_MemWr && (int'(mem_address) < MB - 1)) begin
      mem[ma0] <= mem_data_in[7:0];
      mem[ma1] <= mem_data_in[15:8];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < MB; i++) ref_mem[i] = init_byte(i);
    do_preload = 1'b1;
    @(posedge clk);
    #1 do_preload = 1'b0;
  endtask

  task automatic do_txn(input logic we, input logic byt, input logic sext,
                        input logic [15:0] addr, input logic [15:0] wdata, input int hold,
                        output logic [15:0] rd_got, output logic err_got);
    logic        exp_err;
    logic [15:0] exp_rd, w;
    int          exp_lat, exp_rdc, exp_wrc, lat, rdc, wrc, a;
    logic [15:0] pa, pdi;
    logic        plb, prd, pwr, seen;
    a = int'(addr);
    // Reference model: outcome straight from the access rules.
    exp_err = (a + 1 >= MB);
`ifdef DMEM_ALIGN_CHECK_EN
    if (!byt && addr[0]) exp_err = 1'b1;
`endif
    exp_rd = 16'h0;
    if (exp_err) begin
      exp_lat = 1; exp_rdc = 0; exp_wrc = 0;
    end else if (!we) begin
      w = {ref_mem[a+1], ref_mem[a]};
      if (!byt)                exp_rd = w;
      else if (sext && w[7])   exp_rd = 16'hFF00 + {8'h00, w[7:0]};
      else                     exp_rd = {8'h00, w[7:0]};
      exp_lat = 4; exp_rdc = 1; exp_wrc = 0;
    end else if (byt) begin
      ref_mem[a] = wdata[7:0];
      exp_lat = 6; exp_rdc = 1; exp_wrc = 1;
    end else begin
      ref_mem[a] = wdata[7:0];
      ref_mem[a+1] = wdata[15:8];
      exp_lat = 3; exp_rdc = 0; exp_wrc = 1;
    end

    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_byte = byt; req_sext = sext;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1; rdc = 0; wrc = 0; prd = 1'b0; pwr = 1'b0; seen = 1'b0;
    pa = mem_address; pdi = mem_data_in; plb = mem_LB;
    while (lat <= 20) begin
      @(negedge clk);
      chk("strobe_excl", 32'(mem_MemRd & mem_MemWr), 32'd0);
      if ((mem_MemRd && !prd) || (mem_MemWr && !pwr)) begin
        chk("setup_addr", 32'(mem_address), 32'(pa));
        chk("setup_lb", 32'(mem_LB), 32'(plb));
        if (mem_MemWr) chk("setup_data", 32'(mem_data_in), 32'(pdi));
      end
      if (mem_MemRd) begin
        rdc++;
        chk("read_lb", 32'(mem_LB), 32'(byt & ~we));
      end
      if (mem_MemWr) wrc++;
      chk("busy_ready", 32'(req_ready), 32'd0);
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      pa = mem_address; pdi = mem_data_in; plb = mem_LB; prd = mem_MemRd; pwr = mem_MemWr;
      // Stray requests while busy must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      req_we = 1'($urandom_range(0, 1)); req_byte = 1'($urandom_range(0, 1));
      req_addr = 16'($urandom_range(0, MB - 1)); req_wdata = 16'($urandom);
      @(posedge clk);
      lat++;
    end
    req_valid = 1'b0;
    chk("resp_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rd_cycles", 32'(rdc), 32'(exp_rdc));
    chk("wr_cycles", 32'(wrc), 32'(exp_wrc));
    chk("resp_rdata", 32'(resp_rdata), 32'(exp_rd));
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    rd_got = resp_rdata;
    err_got = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", 32'(resp_rdata), 32'(rd_got));
      chk("hold_err", 32'(resp_err), 32'(err_got));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("exit_valid", 32'(resp_valid), 32'd0);
    chk("exit_ready", 32'(req_ready), 32'd1);
    if (we) for (int i = 0; i < MB; i++) chk("mem_byte", 32'(mem[i]), 32'(ref_mem[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic        e;
    int          n;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_sext = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    preload();
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_strobes", 32'({mem_MemRd, mem_MemWr, mem_LB}), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_data_in", 32'(mem_data_in), 32'd0);
    chk("rst_rdata_err", 32'({resp_rdata, resp_err}), 32'd0);
    rst_n = 1'b1;

    do_txn(1'b0, 1'b0, 1'b0, 16'd0, 16'h0, 1, r, e);
    chk("lit_wload0", 32'({r, e}), 32'({16'h0007, 1'b0}));
    do_txn(1'b0, 1'b1, 1'b1, 16'd2, 16'h0, 0, r, e);
    chk("lit_bload2_sext", 32'(r), 32'h0000FF81);
    do_txn(1'b0, 1'b1, 1'b0, 16'd2, 16'h0, 0, r, e);
    chk("lit_bload2_zext", 32'(r), 32'h00000081);
    do_txn(1'b1, 1'b1, 1'b0, 16'd4, 16'h12AB, 0, r, e);
    chk("lit_bstore4_err", 32'(e), 32'd0);
    do_txn(1'b0, 1'b0, 1'b0, 16'd4, 16'h0, 0, r, e);
    chk("lit_wload4", 32'(r), 32'h000022AB);
    chk("lit_mem5", 32'(mem[5]), 32'h22);
    do_txn(1'b0, 1'b0, 1'b0, 16'd31, 16'h0, 0, r, e);
    chk("lit_wload31", 32'({r, e}), 32'({16'h0000, 1'b1}));
    do_txn(1'b1, 1'b1, 1'b0, 16'd31, 16'h5A5A, 0, r, e);
    chk("lit_bstore31", 32'({r, e}), 32'({16'h0000, 1'b1}));
    do_txn(1'b0, 1'b0, 1'b0, 16'd2, 16'h0, 5, r, e);
    chk("lit_hold_load2", 32'(r), 32'h00001181);
    do_txn(1'b1, 1'b0, 1'b0, 16'd6, 16'hBEEF, 0, r, e);
    do_txn(1'b0, 1'b0, 1'b0, 16'd6, 16'h0, 2, r, e);
    chk("lit_wload6", 32'(r), 32'h0000BEEF);

    for (int k = 0; k < 300; k++) begin
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom_range(0, MB + 2)), 16'($urandom), $urandom_range(0, 3), r, e);
    end

    // Reset while a byte store is in its read strobe.
    preload();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_sext = 1'b0;
    req_addr = 16'd4; req_wdata = 16'h5566;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!mem_MemRd && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_stb", 32'(mem_MemRd), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_strobes", 32'({mem_MemRd, mem_MemWr, mem_LB}), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_resp", 32'({resp_valid, resp_err, resp_rdata}), 32'd0);
    chk("midrst_addr", 32'(mem_address), 32'd0);
    chk("midrst_data_in", 32'(mem_data_in), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_mem4", 32'(mem[4]), 32'h22);
    chk("midrst_mem5", 32'(mem[5]), 32'h22);
    do_txn(1'b0, 1'b0, 1'b0, 16'd4, 16'h0, 0, r, e);
    chk("lit_after_rst", 32'({r, e}), 32'({16'h2222, 1'b0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
